// File: rtl/pwm_out.sv
// pwm_out: multi-channel PWM output stage with per-channel shadow duty
// registers and a run/drain state machine.
//
// Duty values are reloaded only at the period boundary. A stop request lets
// the current period finish before the pins go inactive.
//
// Optional feature macro: PWM_STAGGER_EN
//   When defined, channel k compares a phase-shifted counter
//   (cnt + k*(PWM_INTERVAL/NUM_CH)) mod PWM_INTERVAL, which spreads the LED
//   current peaks across the period. When undefined, all channels compare
//   against cnt directly.
//
// Handshake: en is a plain level request with no ready. It is sampled every
// cycle. A start is taken from IDLE. A stop takes effect at the next period
// wrap. busy reports that the stage is not IDLE.
module pwm_out #(
  parameter int PWM_INTERVAL = 1200,
  parameter int NUM_CH       = 3,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_CH*11-1:0] duty_in,
  output logic [NUM_CH-1:0]    pwm,
  output logic                 period_start,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [10:0]       LAST     = 11'(PWM_INTERVAL - 1);
  localparam logic [10:0]       MAX_DUTY = 11'(PWM_INTERVAL);
  localparam logic [NUM_CH-1:0] INACTIVE = {NUM_CH{ACTIVE_LOW != 0}};

  state_t      state;
  state_t      state_n;
  logic [10:0] cnt;
  logic [10:0] cnt_n;
  logic        reload;
  logic        wrap;
  logic [10:0] duty_q [NUM_CH];
  logic [10:0] phase  [NUM_CH];
  logic [NUM_CH-1:0] raw;

  // Out-of-range duty targets saturate to a fully-on period.
  function automatic logic [10:0] clamp(input logic [10:0] d);
    return (d > MAX_DUTY) ? MAX_DUTY : d;
  endfunction

  assign wrap = (cnt == LAST);

  // Next-state, next-count and shadow-reload decision.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    reload  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (en) begin
          state_n = RUN;
          reload  = 1'b1;
        end
      end
      RUN: begin
        cnt_n = wrap ? 11'd0 : cnt + 11'd1;
        if (wrap) begin
          if (en) reload  = 1'b1;
          else    state_n = IDLE;
        end else if (!en) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        cnt_n = wrap ? 11'd0 : cnt + 11'd1;
        if (wrap) begin
          if (en) begin
            state_n = RUN;
            reload  = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // FSM state, period counter, busy flag and shadow duty registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) duty_q[k] <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      busy  <= (state_n != IDLE);
      if (reload) begin
        for (int k = 0; k < NUM_CH; k++) duty_q[k] <= clamp(duty_in[11*k +: 11]);
      end
    end
  end

`ifdef PWM_STAGGER_EN
  localparam int          STEP   = PWM_INTERVAL / NUM_CH;
  localparam logic [11:0] MAX_12 = {1'b0, MAX_DUTY};
  logic [11:0] sum [NUM_CH];

  // Phase-shifted counter per channel; one conditional subtract wraps it.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      sum[k]   = {1'b0, cnt} + 12'(k * STEP);
      phase[k] = (sum[k] >= MAX_12) ? 11'(sum[k] - MAX_12) : sum[k][10:0];
    end
  end
`else
  // All channels share the global counter and rise together.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) phase[k] = cnt;
  end
`endif

  // Raw duty compare per channel (unsigned, 11 bits).
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) raw[k] = (phase[k] < duty_q[k]);
  end

  // Registered pins and period marker; inactive whenever the stage is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm          <= INACTIVE;
      period_start <= 1'b0;
    end else if (state != IDLE) begin
      pwm          <= raw ^ INACTIVE;
      period_start <= (cnt == 11'd0);
    end else begin
      pwm          <= INACTIVE;
      period_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_out.sv
// tb_pwm_out: table-driven bench for pwm_out with PWM_INTERVAL=12, NUM_CH=3,
// active-low pins. Each vector's expected per-period masks and counts are
// queued when the duty is driven and popped when the period finishes.
`timescale 1ns/1ps
module tb_pwm_out;

  localparam int         PI    = 12;
  localparam int         NCH   = 3;
  localparam logic [2:0] INACT = 3'b111;
`ifdef PWM_STAGGER_EN
  localparam bit STAG = 1'b1;
`else
  localparam bit STAG = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [32:0] duty_in = '0;
  logic [2:0]  pwm;
  logic        ps;
  logic        busy;

  logic        en_b = 1'b0;
  logic [32:0] duty_b = '0;
  logic [2:0]  pwm_b;
  logic        ps_b;
  logic        busy_b;

  always #5 clk = ~clk;

  pwm_out #(.PWM_INTERVAL(PI), .NUM_CH(NCH), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .en(en), .duty_in(duty_in),
    .pwm(pwm), .period_start(ps), .busy(busy)
  );

  pwm_out #(.PWM_INTERVAL(PI), .NUM_CH(NCH), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .duty_in(duty_b),
    .pwm(pwm_b), .period_start(ps_b), .busy(busy_b)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [47:0] exp_q[$];

  typedef struct packed {
    logic [10:0] d2, d1, d0;
    logic [3:0]  n2, n1, n0;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic logic [3:0] clampn(input logic [10:0] d);
    return (d > 11'd12) ? 4'd12 : d[3:0];
  endfunction

  function automatic vec_t mk(input logic [10:0] d2, d1, d0, input logic [3:0] n2, n1, n0);
    vec_t v;
    v.d2 = d2; v.d1 = d1; v.d0 = d0;
    v.n2 = n2; v.n1 = n1; v.n0 = n0;
    return v;
  endfunction

  // Which counter positions of a period should show channel k active.
  function automatic logic [11:0] exp_mask(input logic [10:0] d, input int k);
    int cl;
    int ph;
    logic [11:0] m;
    cl = (d > 11'd12) ? PI : int'(d);
    m  = '0;
    for (int p = 0; p < PI; p++) begin
      ph   = STAG ? (p + k * (PI / NCH)) % PI : p;
      m[p] = (ph < cl);
    end
    return m;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_vec(input vec_t v);
    duty_in = {v.d2, v.d1, v.d0};
    exp_q.push_back({v.n2, v.n1, v.n0,
                     exp_mask(v.d2, 2), exp_mask(v.d1, 1), exp_mask(v.d0, 0)});
  endtask

  task automatic wait_ps(input int limit, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!ps && waited < limit);
    if (!ps) begin
      tests++;
      fails++;
      $display("FAIL ps_timeout: got no period_start, expected one within %0d cycles", limit);
    end
  endtask

  // ---------------- monitor ----------------
  logic        win_on  = 1'b0;
  int          win_pos = 0;
  logic [11:0] m0, m1, m2;

  task automatic close_period();
    logic [47:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL sb_empty: got a period, expected none");
    end else begin
      e = exp_q.pop_front();
      check("duty_count", {4'($countones(m2)), 4'($countones(m1)), 4'($countones(m0))}, e[47:36]);
      check("duty_mask", {m2, m1, m0}, e[35:0]);
    end
  endtask

  // Collect one active mask per channel over each 12-cycle period window.
  always @(negedge clk) begin
    if (rst) begin
      win_on = 1'b0;
    end else begin
      if (ps) begin
        if (win_on) check("period_len", 64'(win_pos), 64'(PI));
        win_on  = 1'b1;
        win_pos = 0;
        m0 = '0; m1 = '0; m2 = '0;
      end
      if (win_on) begin
        m0[win_pos] = ~pwm[0];
        m1[win_pos] = ~pwm[1];
        m2[win_pos] = ~pwm[2];
        win_pos++;
        if (win_pos == PI) begin
          win_on = 1'b0;
          close_period();
        end
      end else begin
        check("idle_pins", pwm, INACT);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int   waited;
    logic bad_busy;
    logic bad_ps;
    logic [10:0] r2, r1, r0;

    vecs[0] = mk(11'd12,   11'd0,  11'd5,    4'd12, 4'd0,  4'd5);
    vecs[1] = mk(11'd12,   11'd0,  11'd9,    4'd12, 4'd0,  4'd9);
    vecs[2] = mk(11'd2000, 11'd13, 11'd2047, 4'd12, 4'd12, 4'd12);
    vecs[3] = mk(11'd0,    11'd1,  11'd11,   4'd0,  4'd1,  4'd11);
    vecs[4] = mk(11'd4,    11'd4,  11'd4,    4'd4,  4'd4,  4'd4);
    vecs[5] = mk(11'd6,    11'd3,  11'd10,   4'd6,  4'd3,  4'd10);
    for (int j = 6; j < 9; j++) begin
      r2 = 11'($urandom_range(0, 15));
      r1 = 11'($urandom_range(0, 15));
      r0 = 11'($urandom_range(0, 15));
      vecs[j] = mk(r2, r1, r0, clampn(r2), clampn(r1), clampn(r0));
    end

    // Reset values while rst is held.
    repeat (3) @(negedge clk);
    check("rst_pwm", pwm, INACT);
    check("rst_busy", busy, 1'b0);
    check("rst_ps", ps, 1'b0);
    check("rst_pwm_active_high", pwm_b, 3'b000);
    #2 rst = 1'b0;

    // Idle with en low for 50 cycles.
    bad_busy = 1'b0;
    bad_ps   = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (busy) bad_busy = 1'b1;
      if (ps)   bad_ps   = 1'b1;
    end
    check("idle_busy", bad_busy, 1'b0);
    check("idle_ps", bad_ps, 1'b0);

    // Start: busy one cycle after en, period_start one cycle after busy.
    apply_vec(vecs[0]);
    en = 1'b1;
    @(negedge clk);
    check("start_busy", busy, 1'b1);
    check("start_ps_early", ps, 1'b0);
    @(negedge clk);
    check("start_ps", ps, 1'b1);

    // Table: new duty driven at cnt=3 takes effect in the following period.
    for (int i = 1; i < 9; i++) begin
      repeat (2) @(negedge clk);
      apply_vec(vecs[i]);
      wait_ps(20, waited);
      check("period_gap", 64'(waited), 64'd10);
    end

    // Drop en at cnt=4, reassert at cnt=8: run resumes at the wrap with reload.
    apply_vec(mk(11'd3, 11'd7, 11'd12, 4'd3, 4'd7, 4'd12));
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    check("drain_busy", busy, 1'b1);
    en = 1'b1;
    wait_ps(20, waited);
    check("resume_gap", 64'(waited), 64'd5);

    // Final stop at cnt=4: period completes, busy falls after the wrap.
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (7) @(negedge clk);
    check("stop_busy_last", busy, 1'b1);
    @(negedge clk);
    check("stop_busy_low", busy, 1'b0);
    bad_ps = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (ps || busy) bad_ps = 1'b1;
    end
    check("stop_quiet", bad_ps, 1'b0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-period with all pins active.
    apply_vec(mk(11'd12, 11'd12, 11'd12, 4'd12, 4'd12, 4'd12));
    en = 1'b1;
    repeat (2) @(negedge clk);
    check("rerun_ps", ps, 1'b1);
    repeat (6) @(negedge clk);
    check("pre_rst_pwm", pwm, 3'b000);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pwm", pwm, INACT);
    check("async_rst_busy", busy, 1'b0);
    exp_q.delete();
    en = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_pwm", pwm, INACT);

    // Idle second instance must have stayed inactive-low throughout.
    check("ah_idle_pwm", pwm_b, 3'b000);
    check("ah_idle_busy", {busy_b, ps_b}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
